// File: rtl/mem_access_unit.sv
// Load/store access unit: accepts one byte/half/word/double operation at a time,
// drives a lane-aligned memory request and returns sign/zero-extended load data.
module mem_access_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 1,
  parameter int WAIT_MAX   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_store,
  input  logic                in_unsigned,
  input  logic [1:0]          in_size,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [4:0]          in_rd,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                out_valid,
  output logic                out_we,
  output logic [4:0]          out_rd,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_err
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_SIZE     = 2'd3;
  localparam logic [7:0] WAIT_LAST    = 8'(WAIT_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                r_alive;
  logic                r_store, r_unsigned;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_data;
  logic [4:0]          r_rd;
  logic [1:0]          r_err;
  logic [7:0]          r_cnt;

  logic                w_accept, w_timeout;
  logic [1:0]          w_in_err;
  logic [3:0]          w_off, w_nbytes, w_lane_lo;
  logic [8:0]          w_mask;
  logic [NB-1:0]       w_be;
  logic [DATA_W-1:0]   w_wdata, w_shifted, w_ext;

  assign w_accept  = in_valid && in_ready;
  assign w_timeout = (r_cnt == WAIT_LAST) && !mem_rvalid;

  always_comb begin
    w_in_err = ERR_NONE;
    if (in_size == 2'd3 && DATA_W != 64) begin
      w_in_err = ERR_SIZE;
    end else begin
      case (in_size)
        2'd1:    if (in_addr[0] != 1'b0)    w_in_err = ERR_MISALIGN;
        2'd2:    if (in_addr[1:0] != 2'b00) w_in_err = ERR_MISALIGN;
        2'd3:    if (in_addr[2:0] != 3'b000) w_in_err = ERR_MISALIGN;
        default: w_in_err = ERR_NONE;
      endcase
    end
  end

  // Lowest lane touched: big-endian puts byte offset 0 in the top lane, so the
  // access occupies lanes NB-off-n .. NB-1-off.
  always_comb begin
    w_off     = 4'(r_addr[OFFW-1:0]);
    w_nbytes  = 4'd1 << r_size;
    w_lane_lo = (BIG_ENDIAN != 0) ? 4'(NB) - w_off - w_nbytes : w_off;
    w_mask    = (9'd1 << w_nbytes) - 9'd1;
    w_be      = NB'(w_mask) << w_lane_lo;
    w_shifted = mem_rdata >> {w_lane_lo, 3'b000};
    case (r_size)
      2'd0:    w_wdata = {NB{r_wdata[7:0]}};
      2'd1:    w_wdata = {(NB/2){r_wdata[15:0]}};
      2'd2:    w_wdata = {(NB/4){r_wdata[31:0]}};
      default: w_wdata = r_wdata;
    endcase
    case (r_size)
      2'd0:    w_ext = r_unsigned ? DATA_W'(w_shifted[7:0])  : DATA_W'($signed(w_shifted[7:0]));
      2'd1:    w_ext = r_unsigned ? DATA_W'(w_shifted[15:0]) : DATA_W'($signed(w_shifted[15:0]));
      2'd2:    w_ext = r_unsigned ? DATA_W'(w_shifted[31:0]) : DATA_W'($signed(w_shifted[31:0]));
      default: w_ext = w_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_in_err != ERR_NONE) ? S_DONE : S_REQ;
      S_REQ:   if (mem_gnt) w_next = r_store ? S_DONE : S_WAIT;
      S_WAIT:  if (mem_rvalid || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) && r_alive;
    mem_req   = (r_state == S_REQ);
    mem_we    = mem_req && r_store;
    mem_addr  = mem_req ? (r_addr & ~ADDR_W'(NB - 1)) : '0;
    mem_be    = mem_we ? w_be : '0;
    mem_wdata = mem_req ? w_wdata : '0;
    out_valid = (r_state == S_DONE);
    out_we    = out_valid && !r_store && (r_err == ERR_NONE);
    out_rd    = out_valid ? r_rd : '0;
    out_data  = out_valid ? r_data : '0;
    out_err   = out_valid ? r_err : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alive    <= 1'b0;
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_err      <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
    end else begin
      r_alive <= 1'b1;
      r_cnt   <= (r_state == S_WAIT) ? r_cnt + 8'd1 : '0;
      if (w_accept) begin
        r_store    <= in_store;
        r_unsigned <= in_unsigned;
        r_size     <= in_size;
        r_addr     <= in_addr;
        r_wdata    <= in_wdata;
        r_rd       <= in_rd;
        r_err      <= w_in_err;
        r_data     <= '0;
      end
      if (r_state == S_WAIT) begin
        if (mem_rvalid)     r_data <= w_ext;
        else if (w_timeout) r_err  <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: three configurations (32-bit big-endian,
// 32-bit little-endian, 64-bit big-endian) checked against a byte-level model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;
  logic        v_valid, v_store, v_uns;
  logic [1:0]  v_size;
  logic [31:0] v_addr;
  logic [63:0] v_wdata;
  logic [4:0]  v_rd;
  logic        m_gnt, m_rvalid;
  logic [63:0] m_rdata;

  logic a_ready, a_req, a_mwe, a_valid, a_we;
  logic [31:0] a_addr, a_wdata, a_data;
  logic [3:0] a_be;
  logic [4:0] a_rd;
  logic [1:0] a_err;
  logic b_ready, b_req, b_mwe, b_valid, b_we;
  logic [31:0] b_addr, b_wdata, b_data;
  logic [3:0] b_be;
  logic [4:0] b_rd;
  logic [1:0] b_err;
  logic c_ready, c_req, c_mwe, c_valid, c_we;
  logic [31:0] c_addr;
  logic [63:0] c_wdata, c_data;
  logic [7:0] c_be;
  logic [4:0] c_rd;
  logic [1:0] c_err;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .WAIT_MAX(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(v_valid && sel == 0), .in_ready(a_ready),
    .in_store(v_store), .in_unsigned(v_uns), .in_size(v_size), .in_addr(v_addr),
    .in_wdata(v_wdata[31:0]), .in_rd(v_rd), .mem_req(a_req), .mem_gnt(m_gnt),
    .mem_we(a_mwe), .mem_addr(a_addr), .mem_be(a_be), .mem_wdata(a_wdata),
    .mem_rvalid(m_rvalid), .mem_rdata(m_rdata[31:0]), .out_valid(a_valid),
    .out_we(a_we), .out_rd(a_rd), .out_data(a_data), .out_err(a_err));

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(0), .WAIT_MAX(15)) u_b (
    .clk(clk), .rst(rst), .in_valid(v_valid && sel == 1), .in_ready(b_ready),
    .in_store(v_store), .in_unsigned(v_uns), .in_size(v_size), .in_addr(v_addr),
    .in_wdata(v_wdata[31:0]), .in_rd(v_rd), .mem_req(b_req), .mem_gnt(m_gnt),
    .mem_we(b_mwe), .mem_addr(b_addr), .mem_be(b_be), .mem_wdata(b_wdata),
    .mem_rvalid(m_rvalid), .mem_rdata(m_rdata[31:0]), .out_valid(b_valid),
    .out_we(b_we), .out_rd(b_rd), .out_data(b_data), .out_err(b_err));

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(1), .WAIT_MAX(6)) u_c (
    .clk(clk), .rst(rst), .in_valid(v_valid && sel == 2), .in_ready(c_ready),
    .in_store(v_store), .in_unsigned(v_uns), .in_size(v_size), .in_addr(v_addr),
    .in_wdata(v_wdata), .in_rd(v_rd), .mem_req(c_req), .mem_gnt(m_gnt),
    .mem_we(c_mwe), .mem_addr(c_addr), .mem_be(c_be), .mem_wdata(c_wdata),
    .mem_rvalid(m_rvalid), .mem_rdata(m_rdata), .out_valid(c_valid),
    .out_we(c_we), .out_rd(c_rd), .out_data(c_data), .out_err(c_err));

  logic        o_ready, o_req, o_mwe, o_valid, o_we;
  logic [31:0] o_addr;
  logic [7:0]  o_be;
  logic [63:0] o_wdata, o_data;
  logic [4:0]  o_rd;
  logic [1:0]  o_err;

  always_comb begin
    case (sel)
      0: begin
        o_ready = a_ready; o_req = a_req; o_mwe = a_mwe; o_valid = a_valid; o_we = a_we;
        o_addr = a_addr; o_be = {4'b0, a_be}; o_wdata = {32'b0, a_wdata};
        o_data = {32'b0, a_data}; o_rd = a_rd; o_err = a_err;
      end
      1: begin
        o_ready = b_ready; o_req = b_req; o_mwe = b_mwe; o_valid = b_valid; o_we = b_we;
        o_addr = b_addr; o_be = {4'b0, b_be}; o_wdata = {32'b0, b_wdata};
        o_data = {32'b0, b_data}; o_rd = b_rd; o_err = b_err;
      end
      default: begin
        o_ready = c_ready; o_req = c_req; o_mwe = c_mwe; o_valid = c_valid; o_we = c_we;
        o_addr = c_addr; o_be = c_be; o_wdata = c_wdata;
        o_data = c_data; o_rd = c_rd; o_err = c_err;
      end
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
    end
  endtask

  // Byte-level reference: walk the accessed addresses and map each to its lane.
  function automatic int lane_of(int nb, bit bem, int a);
    return bem ? nb - 1 - a : a;
  endfunction

  function automatic logic [7:0] m_be(int nb, bit bem, int o, int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[lane_of(nb, bem, o + i)] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_wdata(int nb, int n, logic [63:0] wd);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < nb; l++) r[8*l +: 8] = wd[8*(l % n) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(int nb, bit bem, int o, int n, bit un, logic [63:0] rd);
    logic [63:0] v, ones;
    logic [7:0]  b;
    v = '0;
    ones = '1;
    for (int i = 0; i < n; i++) begin
      b = rd[8*lane_of(nb, bem, o + i) +: 8];
      if (bem) v = (v << 8) | 64'(b);
      else     v = v | (64'(b) << (8 * i));
    end
    if (!un && n < 8 && v[8*n-1]) v = v | (ones << (8 * n));
    if (nb == 4) v[63:32] = '0;
    return v;
  endfunction

  // Called with the clock low and the selected unit idle; returns at the
  // falling edge of the idle cycle following the result.
  task automatic do_op(input int s, input bit st, input bit un, input logic [1:0] sz,
                       input logic [31:0] ad, input logic [63:0] wd, input logic [4:0] rd,
                       input int gdel, input int rdel, input bit rv_gnt, input logic [63:0] rdat);
    int nb, wm, n, o, err, gc, ec;
    bit bem, norm_load;
    logic [63:0] exp_data;
    nb  = (s == 2) ? 8 : 4;
    bem = (s != 1);
    wm  = (s == 0) ? 4 : (s == 1) ? 15 : 6;
    n   = 1 << sz;
    o   = int'(ad % nb);
    err = (sz == 2'd3 && nb == 4) ? 3 : ((ad % n) != 0) ? 1 : 0;
    norm_load = 1'b0;
    exp_data  = '0;
    gc = 0;
    if (err != 0) begin
      ec = 1;
    end else begin
      gc = gdel + 1;
      if (st) ec = gc + 1;
      else if (rdel < wm) begin
        ec = gc + rdel + 2;
        norm_load = 1'b1;
        exp_data  = m_load(nb, bem, o, n, un, rdat);
      end else begin
        ec  = gc + wm + 1;
        err = 2;
      end
    end
    sel = s;
    v_valid = 1'b1; v_store = st; v_uns = un; v_size = sz; v_addr = ad; v_wdata = wd; v_rd = rd;
    #1 chk("in_ready_accept", 64'(o_ready), 64'd1);
    @(posedge clk);
    for (int cyc = 1; cyc <= ec + 1; cyc++) begin
      @(negedge clk);
      v_valid = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = {$urandom, $urandom};
      chk("in_ready", 64'(o_ready), 64'(cyc == ec + 1));
      chk("out_valid", 64'(o_valid), 64'(cyc == ec));
      chk("mem_req", 64'(o_req), 64'(cyc <= gc));
      if (cyc <= gc) begin
        chk("mem_addr", 64'(o_addr), 64'(ad & ~(nb - 1)));
        chk("mem_we", 64'(o_mwe), 64'(st));
        chk("mem_be", 64'(o_be), st ? 64'(m_be(nb, bem, o, n)) : 64'd0);
        if (st) chk("mem_wdata", o_wdata, m_wdata(nb, n, wd));
        if (cyc == gc) begin
          m_gnt = 1'b1;
          m_rvalid = rv_gnt;
        end
      end
      if (norm_load && cyc == gc + rdel + 1) begin
        m_rvalid = 1'b1;
        m_rdata  = rdat;
      end
      if (err == 2 && cyc >= ec) begin
        m_rvalid = 1'b1;
        m_rdata  = rdat;
      end
      if (cyc == ec) begin
        chk("out_err", 64'(o_err), 64'(err));
        chk("out_rd", 64'(o_rd), 64'(rd));
        chk("out_we", 64'(o_we), 64'(!st && err == 0));
        if (norm_load || err == 2) chk("out_data", o_data, exp_data);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sel = 0;
    v_valid = 1'b0; v_store = 1'b0; v_uns = 1'b0; v_size = '0; v_addr = '0; v_wdata = '0; v_rd = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_in_ready", 64'(o_ready), 64'd0);
      chk("rst_mem_req", 64'(o_req), 64'd0);
      chk("rst_mem_we", 64'(o_mwe), 64'd0);
      chk("rst_mem_addr", 64'(o_addr), 64'd0);
      chk("rst_mem_be", 64'(o_be), 64'd0);
      chk("rst_mem_wdata", o_wdata, 64'd0);
      chk("rst_out_valid", 64'(o_valid), 64'd0);
      chk("rst_out_we", 64'(o_we), 64'd0);
      chk("rst_out_rd", 64'(o_rd), 64'd0);
      chk("rst_out_data", o_data, 64'd0);
      chk("rst_out_err", 64'(o_err), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    sel = 0;
    #1 chk("ready_before_edge", 64'(o_ready), 64'd0);
    @(posedge clk);
    #1 chk("ready_first_edge", 64'(o_ready), 64'd1);
    @(negedge clk);

    do_op(0, 1, 0, 2'd0, 32'h103, 64'hAB, 5'd7, 0, 0, 0, 64'd0);
    do_op(0, 0, 0, 2'd0, 32'h101, 64'd0, 5'd9, 0, 3, 0, 64'h12F45678);
    do_op(0, 0, 1, 2'd0, 32'h101, 64'd0, 5'd10, 1, 3, 0, 64'h12F45678);
    do_op(1, 0, 0, 2'd1, 32'h102, 64'd0, 5'd11, 0, 0, 0, 64'h80017FFF);
    do_op(1, 0, 0, 2'd2, 32'h106, 64'd0, 5'd12, 0, 0, 0, 64'd0);
    do_op(0, 0, 0, 2'd2, 32'h200, 64'd0, 5'd13, 0, 10, 0, 64'hDEADBEEF);
    do_op(2, 1, 0, 2'd3, 32'h08, 64'h0123456789ABCDEF, 5'd14, 5, 0, 0, 64'd0);
    do_op(0, 0, 0, 2'd3, 32'h10, 64'd0, 5'd15, 0, 0, 0, 64'd0);
    do_op(1, 0, 0, 2'd2, 32'h40, 64'd0, 5'd16, 2, 1, 1, 64'hCAFEF00D);
    do_op(2, 0, 0, 2'd3, 32'h18, 64'd0, 5'd17, 1, 2, 0, 64'h8877665544332211);
    do_op(2, 0, 0, 2'd0, 32'h1D, 64'd0, 5'd18, 0, 0, 0, 64'h8877665544332211);
    do_op(2, 1, 0, 2'd1, 32'h22, 64'h5A5A1234, 5'd19, 0, 0, 0, 64'd0);

    // Reset while requesting: mem_req must fall without a clock edge.
    sel = 0;
    v_valid = 1'b1; v_store = 1'b0; v_size = 2'd2; v_addr = 32'h300; v_rd = 5'd20;
    @(posedge clk);
    @(negedge clk);
    v_valid = 1'b0;
    chk("req_before_rst", 64'(o_req), 64'd1);
    rst = 1'b0;
    #1 chk("req_async_drop", 64'(o_req), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst_req", 64'(o_ready), 64'd1);
    @(negedge clk);

    // Reset while waiting for load data, with a response arriving later.
    v_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v_valid = 1'b0;
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0;
    rst = 1'b0;
    #1;
    chk("wait_rst_req", 64'(o_req), 64'd0);
    chk("wait_rst_valid", 64'(o_valid), 64'd0);
    chk("wait_rst_ready", 64'(o_ready), 64'd0);
    m_rvalid = 1'b1; m_rdata = 64'h11223344;
    @(negedge clk);
    chk("wait_rst_valid2", 64'(o_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("wait_rst_ready_rel", 64'(o_ready), 64'd1);
    chk("wait_rst_valid_rel", 64'(o_valid), 64'd0);
    @(negedge clk);
    chk("late_rvalid_valid", 64'(o_valid), 64'd0);
    chk("late_rvalid_req", 64'(o_req), 64'd0);
    m_rvalid = 1'b0;
    do_op(0, 0, 0, 2'd1, 32'h302, 64'd0, 5'd21, 0, 1, 0, 64'h00017FFF);

    for (int k = 0; k < 150; k++) begin
      int s, gd, rdl, wmx;
      logic [1:0] sz;
      logic [31:0] ad;
      s   = int'($urandom_range(0, 2));
      wmx = (s == 0) ? 4 : (s == 1) ? 15 : 6;
      sz  = 2'($urandom_range(0, 3));
      ad  = $urandom & 32'hFFFF;
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      gd  = int'($urandom_range(0, 3));
      rdl = ($urandom_range(0, 9) == 0) ? wmx + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      do_op(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, ad, {$urandom, $urandom},
            5'($urandom), gd, rdl, 1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, data path width; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter BIG_ENDIAN, default 1, lane order: 1 = byte offset 0 in the MS lane; 0 = byte offset 0 in lane 0.
REQ-004 Parameter WAIT_MAX, default 15, load-response timeout in cycles; range 1..255.
REQ-005 Port clk, input, 1 bit, the only clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 Port in_valid, input, 1 bit, operation offered; in_ready, output, 1 bit, operation accepted when both are high.
REQ-008 Port in_store, input, 1 bit, store (1) or load (0); in_unsigned, input, 1 bit, zero-extend a load.
REQ-009 Port in_size, input, 2 bits: 0 byte, 1 half, 2 word, 3 double; double is legal only when DATA_W=64.
REQ-010 Port in_addr, input, ADDR_W bits; in_wdata, input, DATA_W bits, right-justified store data; in_rd, input, 5 bits, destination tag.
REQ-011 Port mem_req, output, 1; mem_gnt, input, 1; mem_we, output, 1; mem_addr, output, ADDR_W, lane-aligned; mem_be, output, DATA_W/8; mem_wdata, output, DATA_W.
REQ-012 Port mem_rvalid, input, 1; mem_rdata, input, DATA_W.
REQ-013 Port out_valid, output, 1; out_we, output, 1, register write-back; out_rd, output, 5; out_data, output, DATA_W; out_err, output, 2 bits (0 none, 1 misaligned, 2 timeout, 3 illegal size).

Function
REQ-014 FSM states: IDLE, REQ, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 On acceptance, all in_* fields SHALL be latched; outputs SHALL depend only on the latched copy.
REQ-016 Misaligned access (half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0) or illegal size SHALL go IDLE->DONE with no mem_req and the matching out_err.
REQ-017 REQ state: mem_req=1, with addr/we/be/wdata held stable until the cycle mem_gnt=1; store -> DONE, load -> WAIT.
REQ-018 mem_addr SHALL equal the latched address with its log2(DATA_W/8) LSBs cleared.
REQ-019 mem_be SHALL set 1/2/4/8 contiguous bits for the accessed byte lanes, ordered per BIG_ENDIAN; mem_be=0 for loads.
REQ-020 mem_wdata SHALL replicate the byte/half/word store data across all lanes.
REQ-021 WAIT state: mem_rvalid SHALL be sampled only here; a response arriving in the same cycle as mem_gnt SHALL be ignored.
REQ-022 On mem_rvalid, the selected lane SHALL be extracted and then sign-extended or zero-extended to DATA_W, registered into out_data; next state DONE.
REQ-023 The WAIT counter SHALL clear on entering WAIT; when it reaches WAIT_MAX with no rvalid, the block SHALL go to DONE with out_err=2, out_we=0 and out_data=0.
REQ-024 DONE state: out_valid=1 for exactly one cycle, then IDLE; out_we=1 only for a load with out_err=0.
REQ-025 Minimum latency from accept edge to out_valid: store 2 cycles, load 3 cycles, error 1 cycle.
REQ-026 Back-to-back: a new operation is accepted in the cycle after DONE; there is no overlap.

Reset
REQ-027 While rst=0, state SHALL be IDLE, the counter 0, and every output 0 including in_ready; mem_req SHALL drop asynchronously.
REQ-028 Reset asserted mid-operation SHALL abandon that operation with no out_valid; a later mem_rvalid SHALL be ignored.
REQ-029 After rst deasserts, in_ready=1 on the first clock edge.

Verification
REQ-030 DATA_W=32, BIG_ENDIAN=1, SB addr 0x103, wdata 0xAB, gnt immediate -> mem_addr 0x100, mem_be 0001, mem_wdata 0xABABABAB, out_valid 2 cycles after accept, out_we=0.
REQ-031 LB addr 0x101, rdata 0x12F45678 after 3 wait cycles -> out_data 0xFFFFFFF4, out_rd echoed, out_we=1; LBU at the same address -> 0x000000F4.
REQ-032 LH addr 0x102, BIG_ENDIAN=0, rdata 0x8001_7FFF -> out_data 0xFFFF8001; LW addr 0x106 -> out_err=1, no mem_req, out_valid 1 cycle after accept.
REQ-033 WAIT_MAX=4, load granted with no rvalid -> out_valid with out_err=2, out_data 0, after exactly 4 WAIT cycles; a late rvalid is ignored.
REQ-034 DATA_W=64: SD addr 0x08 -> mem_be 0xFF; size 3 with DATA_W=32 -> out_err=3; mem_gnt held low 5 cycles -> request fields stable throughout.
REQ-035 rst pulsed low while in WAIT -> mem_req and out_valid stay 0, in_ready=1 after release, and the next load completes normally.
